// File: rtl/branch_flag_resolver.sv
// ---------------------------------------------------------------------------
// branch_flag_resolver
//
// Sits after the ALU flag generator. It latches the flag vector of every
// accepted ALU result and resolves RISC-V B-type branch conditions from those
// flags. Each branch yields one registered taken/target decision on a
// valid/ready channel toward the fetch/PC-update logic. It also keeps
// running branch statistics.
//
// Ports
//   clk, reset     rising-edge clock, synchronous active-high reset
//   in_valid       ALU result/flags valid this cycle
//   in_ready       high only in IDLE while reset is low (state-only decode)
//   flags          {extra, overflow, msb, zero}; extra = unsigned a >= b
//   is_branch      1: resolve a branch, 0: latch the flags only
//   funct3         branch condition code
//   pc, imm        branch instruction address and sign-extended offset
//   flush          aborts any pending branch; overrides every other input
//   out_valid      decision valid (held until out_ready)
//   out_ready      consumer accepts the decision
//   taken, target  registered decision; target = pc+imm or pc+4
//   illegal        funct3 was 010 or 011 (never taken)
//   flags_q        flags of the last accepted ALU result
//   branch_count   resolved branches, illegal ones included (wraps)
//   taken_count    taken branches (wraps)
// ---------------------------------------------------------------------------
module branch_flag_resolver #(
   parameter int WORDSIZE = 64,
   parameter int CNTWIDTH = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [3:0]          flags,
   input  logic                is_branch,
   input  logic [2:0]          funct3,
   input  logic [WORDSIZE-1:0] pc,
   input  logic [WORDSIZE-1:0] imm,
   input  logic                flush,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                taken,
   output logic [WORDSIZE-1:0] target,
   output logic                illegal,
   output logic [3:0]          flags_q,
   output logic [CNTWIDTH-1:0] branch_count,
   output logic [CNTWIDTH-1:0] taken_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [WORDSIZE-1:0] PC_STEP  = {{(WORDSIZE-3){1'b0}}, 3'b100};
   localparam logic [CNTWIDTH-1:0] CNT_ZERO = {CNTWIDTH{1'b0}};

   state_t              state;
   state_t              next_state;
   logic                accept;
   logic                eval_done;
   logic [2:0]          funct3_q;
   logic [WORDSIZE-1:0] pc_q;
   logic [WORDSIZE-1:0] imm_q;
   logic                eval_taken;
   logic                eval_illegal;
   logic [WORDSIZE-1:0] eval_target;

   // Condition decode; returns {illegal, taken}. lt is the signed less-than
   // recovered from the sign bit corrected by overflow.
   function automatic logic [1:0] resolve_cond(input logic [2:0] code,
                                               input logic [3:0] fl);
      logic lt;
      lt = fl[1] ^ fl[2];
      case (code)
         3'b000:  resolve_cond = {1'b0, fl[0]};
         3'b001:  resolve_cond = {1'b0, ~fl[0]};
         3'b100:  resolve_cond = {1'b0, lt};
         3'b101:  resolve_cond = {1'b0, ~lt};
         3'b110:  resolve_cond = {1'b0, ~fl[3]};
         3'b111:  resolve_cond = {1'b0, fl[3]};
         default: resolve_cond = 2'b10;
      endcase
   endfunction

   // Readiness is a pure state/reset decode so it never loops back on in_valid.
   assign in_ready = (state == IDLE) && !reset;
   assign accept   = in_valid && in_ready && !flush;
   // The decision is committed only on an unflushed EVAL->RESP edge.
   assign eval_done = (state == EVAL) && !flush;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; flush returns to IDLE from anywhere.
   always_comb begin
      next_state = state;
      if (flush) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (accept && is_branch) begin
                  next_state = EVAL;
               end else begin
                  next_state = IDLE;
               end
            end
            EVAL: next_state = RESP;
            RESP: begin
               if (out_ready) begin
                  next_state = IDLE;
               end else begin
                  next_state = RESP;
               end
            end
            default: next_state = IDLE;
         endcase
      end
   end

   // Decision logic evaluated from the captured branch operands.
   always_comb begin
      eval_taken   = 1'b0;
      eval_illegal = 1'b0;
      eval_target  = pc_q + PC_STEP;
      {eval_illegal, eval_taken} = resolve_cond(funct3_q, flags_q);
      if (eval_taken) begin
         eval_target = pc_q + imm_q;
      end else begin
         eval_target = pc_q + PC_STEP;
      end
   end

   // Flag latch and branch operand capture; only an accept changes them.
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q  <= 4'b0000;
         funct3_q <= 3'b000;
         pc_q     <= {WORDSIZE{1'b0}};
         imm_q    <= {WORDSIZE{1'b0}};
      end else if (accept) begin
         flags_q <= flags;
         if (is_branch) begin
            funct3_q <= funct3;
            pc_q     <= pc;
            imm_q    <= imm;
         end
      end
   end

   // Output registers; the decision is frozen while it waits in RESP.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         taken     <= 1'b0;
         illegal   <= 1'b0;
         target    <= {WORDSIZE{1'b0}};
      end else begin
         out_valid <= (next_state == RESP);
         if (eval_done) begin
            taken   <= eval_taken;
            illegal <= eval_illegal;
            target  <= eval_target;
         end
      end
   end

   // Statistics counters, free-running modulo 2^CNTWIDTH.
   always_ff @(posedge clk) begin
      if (reset) begin
         branch_count <= CNT_ZERO;
         taken_count  <= CNT_ZERO;
      end else if (eval_done) begin
         branch_count <= branch_count + {{(CNTWIDTH-1){1'b0}}, 1'b1};
         taken_count  <= taken_count + {{(CNTWIDTH-1){1'b0}}, eval_taken};
      end
   end

endmodule
